// File: rtl/cache_mem_bridge.sv
// rtl/cache_mem_bridge.sv - serialises one cache block request into word-wide memory beats
// Read beats fill a block buffer that is returned with a 4-phase acknowledge.
module cache_mem_bridge #(
  parameter int BLOCK_SIZE   = 2,
  parameter int WORD_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int OFFSET_WIDTH = $clog2(BLOCK_SIZE)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic                             req_cs,
  input  logic                             req_rw,
  input  logic [BLOCK_SIZE*WORD_WIDTH-1:0] req_data,
  output logic                             resp_ack,
  output logic [BLOCK_SIZE*WORD_WIDTH-1:0] resp_data,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic                             mem_cs,
  output logic                             mem_we,
  output logic [WORD_WIDTH-1:0]            mem_wdata,
  input  logic [WORD_WIDTH-1:0]            mem_rdata,
  input  logic                             mem_ready
);

  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;

  state_t                             state;
  state_t                             state_nxt;
  logic [OFFSET_WIDTH-1:0]            beat;
  logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] base;
  logic                               rw;
  logic [WORD_WIDTH-1:0]              wbuf [BLOCK_SIZE];
  logic [WORD_WIDTH-1:0]              rbuf [BLOCK_SIZE];
  logic                               last_beat;
  logic                               unused_offset;

  // The block offset of the request is forced to zero, so those bits never matter.
  assign unused_offset = ^req_addr[OFFSET_WIDTH-1:0];
  assign last_beat     = (beat == OFFSET_WIDTH'(BLOCK_SIZE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_cs) state_nxt = XFER;
      XFER:    if (mem_ready && last_beat) state_nxt = ACK;
      ACK:     if (!req_cs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    resp_ack  = (state == ACK);
    mem_cs    = (state == XFER);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == XFER) begin
      mem_we    = rw;
      mem_addr  = {base, beat};
      mem_wdata = wbuf[beat];
    end
  end

  // Read buffer survives write transfers; only reset or read beats change it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat <= '0;
      base <= '0;
      rw   <= 1'b0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        wbuf[i] <= '0;
        rbuf[i] <= '0;
      end
    end else begin
      if (state == IDLE && req_cs) begin
        base <= req_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
        rw   <= req_rw;
        beat <= '0;
        for (int i = 0; i < BLOCK_SIZE; i++)
          wbuf[i] <= req_data[i*WORD_WIDTH +: WORD_WIDTH];
      end
      if (state == XFER && mem_ready) begin
        if (!rw) rbuf[beat] <= mem_rdata;
        if (!last_beat) beat <= beat + OFFSET_WIDTH'(1);
      end
    end
  end

  for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_resp
    assign resp_data[g*WORD_WIDTH +: WORD_WIDTH] = rbuf[g];
  end

endmodule

// File: tb/tb_cache_mem_bridge.sv
// tb/tb_cache_mem_bridge.sv - self-checking bench for cache_mem_bridge
// A word-addressed memory model and an expected read buffer predict every beat and response.
module tb_cache_mem_bridge;
  localparam int BS = 2;
  localparam int WW = 32;
  localparam int AW = 32;
  localparam int OW = 1;

  logic              clk;
  logic              rst_n;
  logic [AW-1:0]     req_addr;
  logic              req_cs;
  logic              req_rw;
  logic [BS*WW-1:0]  req_data;
  logic              resp_ack;
  logic [BS*WW-1:0]  resp_data;
  logic [AW-1:0]     mem_addr;
  logic              mem_cs;
  logic              mem_we;
  logic [WW-1:0]     mem_wdata;
  logic [WW-1:0]     mem_rdata;
  logic              mem_ready;

  cache_mem_bridge #(
    .BLOCK_SIZE(BS), .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .OFFSET_WIDTH(OW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_addr(req_addr), .req_cs(req_cs), .req_rw(req_rw), .req_data(req_data),
    .resp_ack(resp_ack), .resp_data(resp_data),
    .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WW-1:0]    mem_model [bit [31:0]];
  logic [BS*WW-1:0] exp_rbuf = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] mem_read(input logic [AW-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // One complete request; memory waits per beat drawn from [wmin,wmax].
  task automatic transfer(input logic [AW-1:0] addr, input logic rw, input logic [BS*WW-1:0] data,
                          input int wmin, input int wmax, input bit drop_cs);
    logic [AW-1:0] base;
    int w;
    int hold;
    base = addr & ~(AW'(BS - 1));
    @(negedge clk);
    req_cs = 1'b1; req_addr = addr; req_rw = rw; req_data = data; mem_ready = 1'b0;
    for (int i = 0; i < BS; i++) begin
      w = $urandom_range(wmax, wmin);
      for (int c = 0; c <= w; c++) begin
        @(negedge clk);
        check("beat_mem_cs", mem_cs, 1);
        check("beat_mem_addr", mem_addr, base + i);
        check("beat_mem_we", mem_we, rw);
        if (rw) check("beat_mem_wdata", mem_wdata, data[i*WW +: WW]);
        check("beat_ack_low", resp_ack, 0);
        if (i == 0 && c == 0) begin
          if (drop_cs) req_cs = 1'b0;
          req_addr = $urandom; req_rw = ~rw; req_data = {$urandom, $urandom};
        end
        mem_ready = (c == w);
        mem_rdata = (c == w && !rw) ? mem_read(base + i) : $urandom;
        if (c == w) begin
          if (rw) mem_model[base + i] = data[i*WW +: WW];
          else    exp_rbuf[i*WW +: WW] = mem_read(base + i);
        end
      end
    end
    @(negedge clk);
    mem_ready = 1'b0;
    check("ack_high", resp_ack, 1);
    check("ack_mem_cs", mem_cs, 0);
    check("ack_mem_addr", mem_addr, 0);
    check("ack_resp_data", resp_data, exp_rbuf);
    if (drop_cs) begin
      @(negedge clk);
      check("ack_one_cycle", resp_ack, 0);
    end else begin
      hold = $urandom_range(2, 0);
      repeat (hold) begin
        @(negedge clk);
        check("ack_hold", resp_ack, 1);
      end
      req_cs = 1'b0;
      @(negedge clk);
      check("ack_release", resp_ack, 0);
    end
    check("idle_mem_cs", mem_cs, 0);
    check("idle_resp_data", resp_data, exp_rbuf);
  endtask

  initial begin
    rst_n = 1'b0; req_cs = 1'b0; req_rw = 1'b0; req_addr = '0; req_data = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ack", resp_ack, 0);
    check("rst_mem_cs", mem_cs, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_resp_data", resp_data, 0);
    rst_n = 1'b1;

    transfer(32'h103, 1'b1, {32'hBBBB_0001, 32'hAAAA_0000}, 0, 0, 1'b0);
    check("wr_mem_lo", mem_model[32'h102], 32'hAAAA_0000);
    check("wr_mem_hi", mem_model[32'h103], 32'hBBBB_0001);

    mem_model[32'h40] = 32'h11;
    mem_model[32'h41] = 32'h22;
    transfer(32'h40, 1'b0, '0, 0, 0, 1'b0);
    check("rd_block", resp_data, {32'h22, 32'h11});

    transfer(32'h200, 1'b0, '0, 3, 3, 1'b0);

    transfer(32'h301, 1'b1, {$urandom, $urandom}, 0, 1, 1'b0);
    transfer(32'h102, 1'b0, '0, 0, 1, 1'b0);
    check("b2b_readback", resp_data, {32'hBBBB_0001, 32'hAAAA_0000});

    transfer(32'h500, 1'b0, '0, 0, 2, 1'b1);

    @(negedge clk);
    req_cs = 1'b1; req_addr = 32'h80; req_rw = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("rst_mid_beat0", mem_cs, 1);
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_0001;
    @(negedge clk);
    check("rst_mid_beat1_addr", mem_addr, 32'h81);
    check("rst_mid_partial", resp_data, {exp_rbuf[2*WW-1:WW], 32'hDEAD_0001});
    rst_n = 1'b0; mem_ready = 1'b0; req_cs = 1'b0;
    #1;
    check("rst_mid_mem_cs", mem_cs, 0);
    check("rst_mid_resp_data", resp_data, 0);
    check("rst_mid_ack", resp_ack, 0);
    exp_rbuf = '0;
    @(negedge clk);
    rst_n = 1'b1;
    transfer(32'h80, 1'b0, '0, 0, 2, 1'b0);

    for (int k = 0; k < 24; k++)
      transfer($urandom_range(63, 0), 1'($urandom_range(1, 0)), {$urandom, $urandom},
               0, 3, 1'($urandom_range(1, 0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
